// File: rtl/wb_pkg.sv
// wb_pkg: flag-bit positions and the lane packet layout shared by the writeback stage.
package wb_pkg;
  localparam int FLAG_REGWR = 4;
  localparam int FLAG_COND  = 5;
  localparam int FLAG_W     = 8;
  typedef struct packed {
    logic [7:0]  mask;
    logic [7:0]  flags;
    logic [6:0]  alid;
    logic [6:0]  pdest;
    logic [31:0] data;
  } wb_lane_t;
endpackage

// File: rtl/wb_ldv_delay.sv
// wb_ldv_delay: DEPTH-stage load-violation pipeline; valid shifts every cycle, alid loads only with valid.
module wb_ldv_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W:0]   i_ldv,
  output logic [W:0]   o_ldv
);
  logic [DEPTH:0] w_v;
  logic [W-1:0]   w_id [DEPTH+1];
  assign w_v[0]  = i_ldv[W];
  assign w_id[0] = i_ldv[W-1:0];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         r_v;
    logic [W-1:0] r_id;
    always_ff @(posedge clk)
      if (reset) begin
        r_v  <= 1'b0;
        r_id <= '0;
      end else begin
        r_v <= w_v[i];
        if (w_v[i]) r_id <= w_id[i];
      end
    assign w_v[i+1]  = r_v;
    assign w_id[i+1] = r_id;
  end
  assign o_ldv = {w_v[DEPTH], w_id[DEPTH]};
endmodule

// File: rtl/writeback_param.sv
// writeback_param: registers lane results, squashes by checkpoint mask, forwards branch resolution.
// Optional WB_PERF_CNT_EN adds saturating writeback/squash counters.
module writeback_param
  import wb_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int BR_LANE     = 2,
  parameter int CHECKPOINTS = 8,
  parameter int CKPT_LOG    = 3,
  parameter int AL_LOG      = 7,
  parameter int PHYS_LOG    = 7,
  parameter int DATA_W      = 32,
  parameter int PC_W        = 32,
  parameter int CTI_LOG     = 4,
  parameter int WB_FLAGS    = 4,
  parameter int LDV_DEPTH   = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_LANES-1:0]                  exe_valid_i,
  input  logic [NUM_LANES*CHECKPOINTS-1:0]      exe_mask_i,
  input  logic [NUM_LANES*FLAG_W-1:0]           exe_flags_i,
  input  logic [NUM_LANES*AL_LOG-1:0]           exe_alid_i,
  input  logic [NUM_LANES*PHYS_LOG-1:0]         exe_pdest_i,
  input  logic [NUM_LANES*DATA_W-1:0]           exe_data_i,
  input  logic                                  br_mispredict_i,
  input  logic [CKPT_LOG-1:0]                   br_ckpt_i,
  input  logic [PC_W-1:0]                       br_target_i,
  input  logic                                  br_dir_i,
  input  logic [CTI_LOG-1:0]                    br_cti_i,
  input  logic [AL_LOG:0]                       ldv_i,
  output logic [NUM_LANES-1:0]                  wb_valid_o,
  output logic [NUM_LANES*(AL_LOG+WB_FLAGS)-1:0] wb_ctrl_o,
  output logic [NUM_LANES-1:0]                  bypass_valid_o,
  output logic [NUM_LANES*(PHYS_LOG+DATA_W)-1:0] bypass_pkt_o,
  output logic                                  ctrl_verified_o,
  output logic                                  ctrl_mispredict_o,
  output logic                                  ctrl_conditional_o,
  output logic [CKPT_LOG-1:0]                   ctrl_ckpt_o,
  output logic [PC_W-1:0]                       ctrl_target_o,
  output logic                                  ctrl_dir_o,
  output logic [CTI_LOG-1:0]                    ctrl_cti_o,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]                           perf_wb_cnt_o,
  output logic [31:0]                           perf_squash_cnt_o,
`endif
  output logic [AL_LOG:0]                       ldv_o
);
  localparam int CW = AL_LOG + WB_FLAGS;
  localparam int PW = PHYS_LOG + DATA_W;
  logic                   r_mispredict, r_dir, r_kill_d;
  logic [CKPT_LOG-1:0]    r_ckpt, r_ckpt_d;
  logic [PC_W-1:0]        r_target;
  logic [CTI_LOG-1:0]     r_cti;
  logic                   w_kill, w_clr;
  logic [CHECKPOINTS-1:0] w_clr_mask;
  logic [NUM_LANES-1:0]   w_valid_q, w_kill_sq, w_shadow_sq;
  logic [FLAG_W-1:0]      w_flags_q [NUM_LANES];
  assign w_kill     = ctrl_verified_o & ctrl_mispredict_o;
  assign w_clr      = ctrl_verified_o & ~ctrl_mispredict_o;
  assign w_clr_mask = w_clr ? (CHECKPOINTS'(1) << r_ckpt) : '0;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic                   r_v;
    logic [CHECKPOINTS-1:0] r_m;
    logic [FLAG_W-1:0]      r_f;
    logic [AL_LOG-1:0]      r_a;
    logic [PHYS_LOG-1:0]    r_p;
    logic [DATA_W-1:0]      r_d;
    logic [CHECKPOINTS-1:0] w_m_in;
    logic                   w_shadow, w_kill_hit;
    assign w_m_in     = exe_mask_i[i*CHECKPOINTS +: CHECKPOINTS];
    assign w_shadow   = r_kill_d & w_m_in[r_ckpt_d];
    // the branch lane's own checkpoint bit refers to itself, not to an older branch
    assign w_kill_hit = (i == BR_LANE) ? 1'b0 : w_kill & r_m[r_ckpt];
    always_ff @(posedge clk)
      if (reset) begin
        r_v <= 1'b0;
        r_m <= '0;
        r_f <= '0;
        r_a <= '0;
        r_p <= '0;
        r_d <= '0;
      end else begin
        r_v <= exe_valid_i[i] & ~w_shadow;
        if (exe_valid_i[i]) begin
          r_m <= w_m_in & ~w_clr_mask;
          r_f <= exe_flags_i[i*FLAG_W +: FLAG_W];
          r_a <= exe_alid_i[i*AL_LOG +: AL_LOG];
          r_p <= exe_pdest_i[i*PHYS_LOG +: PHYS_LOG];
          r_d <= exe_data_i[i*DATA_W +: DATA_W];
        end
      end
    assign w_valid_q[i]          = r_v;
    assign w_flags_q[i]          = r_f;
    assign w_kill_sq[i]          = r_v & w_kill_hit;
    assign w_shadow_sq[i]        = exe_valid_i[i] & w_shadow;
    assign wb_valid_o[i]         = r_v & ~w_kill_hit;
    assign bypass_valid_o[i]     = r_v & ~w_kill_hit & r_f[FLAG_REGWR];
    assign wb_ctrl_o[i*CW +: CW] = {r_a, r_f[WB_FLAGS-1:0]};
    assign bypass_pkt_o[i*PW +: PW] = {r_p, r_d};
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_mispredict <= 1'b0;
      r_dir        <= 1'b0;
      r_ckpt       <= '0;
      r_target     <= '0;
      r_cti        <= '0;
      r_kill_d     <= 1'b0;
      r_ckpt_d     <= '0;
    end else begin
      r_kill_d <= w_kill;
      r_ckpt_d <= r_ckpt;
      if (exe_valid_i[BR_LANE]) begin
        r_mispredict <= br_mispredict_i;
        r_dir        <= br_dir_i;
        r_ckpt       <= br_ckpt_i;
        r_target     <= br_target_i;
        r_cti        <= br_cti_i;
      end
    end
  assign ctrl_verified_o    = w_valid_q[BR_LANE];
  assign ctrl_mispredict_o  = r_mispredict;
  assign ctrl_conditional_o = w_flags_q[BR_LANE][FLAG_COND];
  assign ctrl_ckpt_o        = r_ckpt;
  assign ctrl_target_o      = r_target;
  assign ctrl_dir_o         = r_dir;
  assign ctrl_cti_o         = r_cti;
`ifdef WB_PERF_CNT_EN
  logic [32:0] w_wb_sum, w_sq_sum;
  assign w_wb_sum = {1'b0, perf_wb_cnt_o} + 33'($countones(wb_valid_o));
  assign w_sq_sum = {1'b0, perf_squash_cnt_o} + 33'($countones(w_kill_sq)) + 33'($countones(w_shadow_sq));
  always_ff @(posedge clk)
    if (reset) begin
      perf_wb_cnt_o     <= '0;
      perf_squash_cnt_o <= '0;
    end else begin
      perf_wb_cnt_o     <= w_wb_sum[32] ? '1 : w_wb_sum[31:0];
      perf_squash_cnt_o <= w_sq_sum[32] ? '1 : w_sq_sum[31:0];
    end
`endif
  wb_ldv_delay #(.DEPTH(LDV_DEPTH), .W(AL_LOG)) u_ldv (
    .clk   (clk),
    .reset (reset),
    .i_ldv (ldv_i),
    .o_ldv (ldv_o)
  );
endmodule

// File: tb/tb_writeback_param.sv
// tb_writeback_param: directed checks of writeback, squash, mask clear, ldv delay and optional counters.
module tb_writeback_param;
  import wb_pkg::*;
  localparam int NL = 4, CP = 8, AL = 7, PH = 7, DW = 32, CW = AL + 4, PW = PH + DW;
  logic              clk = 0, reset = 1;
  logic [NL-1:0]     exe_valid_i;
  logic [NL*CP-1:0]  exe_mask_i;
  logic [NL*8-1:0]   exe_flags_i;
  logic [NL*AL-1:0]  exe_alid_i;
  logic [NL*PH-1:0]  exe_pdest_i;
  logic [NL*DW-1:0]  exe_data_i;
  logic              br_mispredict_i, br_dir_i;
  logic [2:0]        br_ckpt_i;
  logic [31:0]       br_target_i;
  logic [3:0]        br_cti_i;
  logic [AL:0]       ldv_i;
  logic [NL-1:0]     wb_valid_o, bypass_valid_o;
  logic [NL*CW-1:0]  wb_ctrl_o;
  logic [NL*PW-1:0]  bypass_pkt_o;
  logic              ctrl_verified_o, ctrl_mispredict_o, ctrl_conditional_o, ctrl_dir_o;
  logic [2:0]        ctrl_ckpt_o;
  logic [31:0]       ctrl_target_o;
  logic [3:0]        ctrl_cti_o;
  logic [AL:0]       ldv_o;
`ifdef WB_PERF_CNT_EN
  logic [31:0]       perf_wb_cnt_o, perf_squash_cnt_o;
`endif
  int checks = 0, errors = 0;
  writeback_param #(.LDV_DEPTH(3)) dut (
    .clk(clk), .reset(reset),
    .exe_valid_i(exe_valid_i), .exe_mask_i(exe_mask_i), .exe_flags_i(exe_flags_i),
    .exe_alid_i(exe_alid_i), .exe_pdest_i(exe_pdest_i), .exe_data_i(exe_data_i),
    .br_mispredict_i(br_mispredict_i), .br_ckpt_i(br_ckpt_i), .br_target_i(br_target_i),
    .br_dir_i(br_dir_i), .br_cti_i(br_cti_i), .ldv_i(ldv_i),
    .wb_valid_o(wb_valid_o), .wb_ctrl_o(wb_ctrl_o), .bypass_valid_o(bypass_valid_o),
    .bypass_pkt_o(bypass_pkt_o), .ctrl_verified_o(ctrl_verified_o),
    .ctrl_mispredict_o(ctrl_mispredict_o), .ctrl_conditional_o(ctrl_conditional_o),
    .ctrl_ckpt_o(ctrl_ckpt_o), .ctrl_target_o(ctrl_target_o), .ctrl_dir_o(ctrl_dir_o),
    .ctrl_cti_o(ctrl_cti_o),
`ifdef WB_PERF_CNT_EN
    .perf_wb_cnt_o(perf_wb_cnt_o), .perf_squash_cnt_o(perf_squash_cnt_o),
`endif
    .ldv_o(ldv_o)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    exe_valid_i = '0; exe_mask_i = '0; exe_flags_i = '0; exe_alid_i = '0;
    exe_pdest_i = '0; exe_data_i = '0; br_mispredict_i = 0; br_ckpt_i = '0;
    br_target_i = '0; br_dir_i = 0; br_cti_i = '0; ldv_i = '0;
  endtask
  task automatic lane(input int l, input wb_lane_t pk);
    exe_valid_i[l] = 1'b1;
    exe_mask_i[l*CP +: CP]  = pk.mask;
    exe_flags_i[l*8 +: 8]   = pk.flags;
    exe_alid_i[l*AL +: AL]  = pk.alid;
    exe_pdest_i[l*PH +: PH] = pk.pdest;
    exe_data_i[l*DW +: DW]  = pk.data;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    idle();
    step(); step();
    reset = 0;
    chk("rst_wb_valid", 64'(wb_valid_o), 64'h0);
    chk("rst_bypass_pkt", 64'(bypass_pkt_o[PW-1:0]), 64'h0);
    chk("rst_verified", 64'(ctrl_verified_o), 64'h0);
    chk("rst_ldv", 64'(ldv_o), 64'h0);
    lane(0, '{mask:8'h00, flags:8'h10, alid:7'd5, pdest:7'd9, data:32'hDEADBEEF});
    step(); idle();
    chk("basic_wb_valid", 64'(wb_valid_o), 64'h1);
    chk("basic_bypass_valid", 64'(bypass_valid_o), 64'h1);
    chk("basic_bypass_pkt", 64'(bypass_pkt_o[PW-1:0]), 64'h9_DEADBEEF);
    chk("basic_wb_ctrl", 64'(wb_ctrl_o[CW-1:0]), 64'h50);
    chk("basic_verified", 64'(ctrl_verified_o), 64'h0);
    lane(2, '{mask:8'h08, flags:8'h20, alid:7'd1, pdest:7'd0, data:32'h0});
    lane(1, '{mask:8'h08, flags:8'h10, alid:7'd2, pdest:7'd3, data:32'h11});
    lane(0, '{mask:8'h01, flags:8'h00, alid:7'd3, pdest:7'd4, data:32'h22});
    br_mispredict_i = 1; br_ckpt_i = 3'd3; br_target_i = 32'h1000; br_dir_i = 1; br_cti_i = 4'd7;
    step(); idle();
    chk("kill_wb_valid", 64'(wb_valid_o), 64'h5);
    chk("kill_bypass_valid", 64'(bypass_valid_o), 64'h0);
    chk("kill_mispredict", 64'(ctrl_mispredict_o), 64'h1);
    chk("kill_verified", 64'(ctrl_verified_o), 64'h1);
    chk("kill_conditional", 64'(ctrl_conditional_o), 64'h1);
    chk("kill_ckpt", 64'(ctrl_ckpt_o), 64'h3);
    chk("kill_target", 64'(ctrl_target_o), 64'h1000);
    chk("kill_cti", 64'(ctrl_cti_o), 64'h7);
    step();
    chk("gap_wb_valid", 64'(wb_valid_o), 64'h0);
    lane(0, '{mask:8'h08, flags:8'h10, alid:7'd4, pdest:7'd5, data:32'h33});
    lane(3, '{mask:8'h01, flags:8'h10, alid:7'd6, pdest:7'd7, data:32'h44});
    step(); idle();
    chk("shadow_wb_valid", 64'(wb_valid_o), 64'h8);
    lane(2, '{mask:8'h00, flags:8'h20, alid:7'd8, pdest:7'd0, data:32'h0});
    br_ckpt_i = 3'd2;
    step(); idle();
    chk("correct_verified", 64'(ctrl_verified_o), 64'h1);
    chk("correct_mispredict", 64'(ctrl_mispredict_o), 64'h0);
    chk("correct_wb_valid", 64'(wb_valid_o), 64'h4);
    lane(3, '{mask:8'h04, flags:8'h10, alid:7'd9, pdest:7'd10, data:32'h55});
    lane(2, '{mask:8'h00, flags:8'h20, alid:7'd10, pdest:7'd0, data:32'h0});
    br_mispredict_i = 1; br_ckpt_i = 3'd2;
    step(); idle();
    chk("clear_mispredict", 64'(ctrl_mispredict_o), 64'h1);
    chk("clear_wb_valid", 64'(wb_valid_o), 64'hC);
    step();
    chk("clear_gap_wb_valid", 64'(wb_valid_o), 64'h0);
    lane(1, '{mask:8'h04, flags:8'h10, alid:7'd11, pdest:7'd12, data:32'h66});
    lane(0, '{mask:8'h02, flags:8'h10, alid:7'd12, pdest:7'd13, data:32'h77});
    step(); idle();
    chk("shadow2_wb_valid", 64'(wb_valid_o), 64'h1);
    ldv_i = {1'b1, 7'd42};
    step(); idle();
    step();
    chk("ldv_early", 64'(ldv_o), 64'h0);
    step();
    chk("ldv_arrive", 64'(ldv_o), 64'hAA);
    step();
    chk("ldv_hold_alid", 64'(ldv_o), 64'd42);
    ldv_i = {1'b1, 7'd17};
    lane(2, '{mask:8'h00, flags:8'h20, alid:7'd1, pdest:7'd0, data:32'h0});
    br_mispredict_i = 1; br_ckpt_i = 3'd1;
    step(); idle();
    reset = 1;
    lane(0, '{mask:8'h02, flags:8'h10, alid:7'd1, pdest:7'd1, data:32'h1});
    step(); idle();
    reset = 0;
    chk("midrst_wb_valid", 64'(wb_valid_o), 64'h0);
    chk("midrst_verified", 64'(ctrl_verified_o), 64'h0);
    chk("midrst_mispredict", 64'(ctrl_mispredict_o), 64'h0);
    chk("midrst_ldv", 64'(ldv_o), 64'h0);
    lane(0, '{mask:8'h02, flags:8'h10, alid:7'd1, pdest:7'd1, data:32'h1});
    step(); idle();
    chk("midrst_no_shadow", 64'(wb_valid_o), 64'h1);
    chk("midrst_ldv_later", 64'(ldv_o), 64'h0);
    step();
    chk("midrst_ldv_end", 64'(ldv_o), 64'h0);
`ifdef WB_PERF_CNT_EN
    reset = 1;
    step();
    reset = 0;
    chk("perf_rst_wb", 64'(perf_wb_cnt_o), 64'd0);
    chk("perf_rst_sq", 64'(perf_squash_cnt_o), 64'd0);
    for (int k = 0; k < 10; k++) begin
      for (int l = 0; l < NL; l++) lane(l, '{mask:8'h00, flags:8'h10, alid:7'(l), pdest:7'(l), data:32'(k)});
      step();
    end
    idle();
    step();
    chk("perf_wb_40", 64'(perf_wb_cnt_o), 64'd40);
    chk("perf_sq_0", 64'(perf_squash_cnt_o), 64'd0);
    lane(2, '{mask:8'h00, flags:8'h20, alid:7'd1, pdest:7'd0, data:32'h0});
    lane(1, '{mask:8'h01, flags:8'h10, alid:7'd2, pdest:7'd2, data:32'h2});
    br_mispredict_i = 1; br_ckpt_i = 3'd0;
    step(); idle();
    step();
    chk("perf_wb_41", 64'(perf_wb_cnt_o), 64'd41);
    chk("perf_sq_1", 64'(perf_squash_cnt_o), 64'd1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
